// File: rtl/bvm_pkg.sv
// Shared types and constants for the payment controller and the dispenser.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package bvm_pkg;

  // Width of every credit-valued signal (credit, change, price)
  localparam int CREDIT_W = 7;

  // Controller states
  typedef enum logic [2:0] {
    ST_COLLECT   = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_ACK  = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_CHANGE    = 3'd4
  } bvm_state_e;

  // Beverage codes, identical to the dispenser's BVMin encoding
  localparam logic [1:0] BEV_WATER  = 2'b00;
  localparam logic [1:0] BEV_MILK   = 2'b01;
  localparam logic [1:0] BEV_TEA    = 2'b10;
  localparam logic [1:0] BEV_COFFEE = 2'b11;

  // Credit units represented by each coin code
  function automatic logic [3:0] coin_value(input logic [1:0] coin_type);
    logic [3:0] v;
    case (coin_type)
      2'b00:   v = 4'd1;
      2'b01:   v = 4'd2;
      2'b10:   v = 4'd5;
      default: v = 4'd10;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/bvm_payment_ctrl_if.sv
// Coin/selection inputs, dispenser handshake and status outputs of the controller.
// Latency: none (wiring only).
// Backpressure: BVMd is held until the dispenser raises BVMvalid.
interface bvm_payment_ctrl_if;
  import bvm_pkg::*;

  logic                coin_valid;
  logic [1:0]          coin_type;
  logic                sel_valid;
  logic [1:0]          sel;
  logic                cancel;
  logic                BVMvalid;
  logic                BVMd;
  logic [1:0]          BVMin;
  logic [CREDIT_W-1:0] credit;
  logic                ready;
  logic                coin_reject;
  logic                sel_reject;
  logic                change_valid;
  logic [CREDIT_W-1:0] change_amt;

  // Environment side: coin mechanism, keypad and dispenser
  modport master (
    output coin_valid, coin_type, sel_valid, sel, cancel, BVMvalid,
    input  BVMd, BVMin, credit, ready, coin_reject, sel_reject,
           change_valid, change_amt
  );

  // Controller side
  modport slave (
    input  coin_valid, coin_type, sel_valid, sel, cancel, BVMvalid,
    output BVMd, BVMin, credit, ready, coin_reject, sel_reject,
           change_valid, change_amt
  );

endinterface

// File: rtl/bvm_price_lut.sv
// Maps a beverage code to its price in credit units.
// Latency: combinational.
// Backpressure: none.
module bvm_price_lut
  import bvm_pkg::*;
#(
  parameter int unsigned PRICE_WATER  = 5,
  parameter int unsigned PRICE_MILK   = 10,
  parameter int unsigned PRICE_TEA    = 15,
  parameter int unsigned PRICE_COFFEE = 20
) (
  input  logic [1:0]          sel,
  output logic [CREDIT_W-1:0] price
);

  // Price lookup by beverage code
  always_comb begin
    price = CREDIT_W'(PRICE_WATER);
    case (sel)
      BEV_WATER:  price = CREDIT_W'(PRICE_WATER);
      BEV_MILK:   price = CREDIT_W'(PRICE_MILK);
      BEV_TEA:    price = CREDIT_W'(PRICE_TEA);
      BEV_COFFEE: price = CREDIT_W'(PRICE_COFFEE);
      default:    price = CREDIT_W'(PRICE_WATER);
    endcase
  end

endmodule

// File: rtl/bvm_payment_ctrl.sv
// Coin credit accumulator and selection checker driving the dispenser request.
// Latency: BVMd rises on the edge that accepts a selection; change strobes one cycle after dispense ends.
// Backpressure: BVMd held until BVMvalid (or timeout); coins/selections rejected while not in COLLECT.
module bvm_payment_ctrl
  import bvm_pkg::*;
#(
  parameter int unsigned PRICE_WATER  = 5,
  parameter int unsigned PRICE_MILK   = 10,
  parameter int unsigned PRICE_TEA    = 15,
  parameter int unsigned PRICE_COFFEE = 20,
  parameter int unsigned MAX_CREDIT   = 100,
  parameter int unsigned ACK_TIMEOUT  = 4
) (
  input logic               BVMclk,
  input logic               BVMrst,
  bvm_payment_ctrl_if.slave bus
);

  localparam logic [2:0] COLLECT   = ST_COLLECT;
  localparam logic [2:0] ISSUE     = ST_ISSUE;
  localparam logic [2:0] WAIT_ACK  = ST_WAIT_ACK;
  localparam logic [2:0] WAIT_DONE = ST_WAIT_DONE;
  localparam logic [2:0] CHANGE    = ST_CHANGE;

  localparam logic [7:0] MAX_C    = 8'(MAX_CREDIT);
  // Last timer value before abort: WAIT_ACK lasts exactly ACK_TIMEOUT cycles
  localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

  logic [2:0]          state;
  logic [7:0]          timer;
  logic [CREDIT_W-1:0] price;
  logic [7:0]          coin_sum;
  logic                coin_fits;
  logic                sel_ok;
  logic [CREDIT_W-1:0] sel_left;

  bvm_price_lut #(
    .PRICE_WATER  (PRICE_WATER),
    .PRICE_MILK   (PRICE_MILK),
    .PRICE_TEA    (PRICE_TEA),
    .PRICE_COFFEE (PRICE_COFFEE)
  ) u_price (
    .sel   (bus.sel),
    .price (price)
  );

  // Credit arithmetic in 8 bits so an over-limit coin cannot wrap into range
  always_comb begin
    coin_sum  = {1'b0, bus.credit} + {4'b0000, coin_value(bus.coin_type)};
    coin_fits = (coin_sum <= MAX_C);
    sel_ok    = ({1'b0, bus.credit} >= {1'b0, price});
    sel_left  = bus.credit - price;
  end

  // Transaction FSM; every output is a register updated here
  always_ff @(posedge BVMclk) begin
    if (BVMrst) begin
      state            <= COLLECT;
      timer            <= '0;
      bus.credit       <= '0;
      bus.BVMd         <= 1'b0;
      bus.BVMin        <= 2'b00;
      bus.ready        <= 1'b1;
      bus.coin_reject  <= 1'b0;
      bus.sel_reject   <= 1'b0;
      bus.change_valid <= 1'b0;
      bus.change_amt   <= '0;
    end else begin
      // Pulses default low; anything arriving mid-transaction is bounced
      bus.coin_reject  <= (state != COLLECT) && bus.coin_valid;
      bus.sel_reject   <= (state != COLLECT) && bus.sel_valid;
      bus.change_valid <= 1'b0;
      case (state)
        COLLECT: begin
          if (bus.cancel) begin
            bus.change_amt   <= bus.credit;
            bus.credit       <= '0;
            bus.change_valid <= 1'b1;
            bus.ready        <= 1'b0;
            bus.coin_reject  <= bus.coin_valid;
            state            <= CHANGE;
          end else if (bus.sel_valid && sel_ok) begin
            // Displayed credit stays until the transaction completes
            bus.BVMin       <= bus.sel;
            bus.change_amt  <= sel_left;
            bus.BVMd        <= 1'b1;
            bus.ready       <= 1'b0;
            bus.coin_reject <= bus.coin_valid;
            state           <= ISSUE;
          end else begin
            bus.sel_reject <= bus.sel_valid;
            if (bus.coin_valid) begin
              if (coin_fits) begin
                bus.credit <= coin_sum[CREDIT_W-1:0];
              end else begin
                bus.coin_reject <= 1'b1;
              end
            end
          end
        end
        ISSUE: begin
          timer <= '0;
          state <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (bus.BVMvalid) begin
            // Drop the request on acknowledge so a freed dispenser is not re-triggered
            bus.BVMd <= 1'b0;
            state    <= WAIT_DONE;
          end else if (timer == TMO_LAST) begin
            bus.BVMd         <= 1'b0;
            bus.change_amt   <= bus.credit;
            bus.credit       <= '0;
            bus.change_valid <= 1'b1;
            state            <= CHANGE;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        WAIT_DONE: begin
          if (!bus.BVMvalid) begin
            bus.credit       <= '0;
            bus.change_valid <= 1'b1;
            state            <= CHANGE;
          end
        end
        CHANGE: begin
          bus.ready <= 1'b1;
          state     <= COLLECT;
        end
        default: begin
          bus.BVMd  <= 1'b0;
          bus.ready <= 1'b1;
          state     <= COLLECT;
        end
      endcase
    end
  end

endmodule

// File: doc/bvm_payment_ctrl.md
Name: bvm_payment_ctrl

Overview:
Coin-and-selection front end that sits directly upstream of the beverage dispenser. It accumulates coin credit and checks each selection against its price. For an accepted selection it issues the dispenser request on BVMd/BVMin and holds it until the dispenser's BVMvalid busy flag acknowledges it. After dispensing ends it returns change. All inputs are ignored or rejected while a dispense is in flight.

Parameters:
PRICE_WATER, 5, price of selection 2'b00 in credit units
PRICE_MILK, 10, price of selection 2'b01
PRICE_TEA, 15, price of selection 2'b10
PRICE_COFFEE, 20, price of selection 2'b11
MAX_CREDIT, 100, credit ceiling; must be <= 127
ACK_TIMEOUT, 4, cycles in WAIT_ACK before abort/refund; must be >= 2

Ports:
BVMclk  in  1  system clock, rising edge
BVMrst  in  1  synchronous reset, active-high
coin_valid  in  1  one-cycle coin insertion strobe
coin_type  in  2  00=1, 01=2, 10=5, 11=10 credit units
sel_valid  in  1  one-cycle selection strobe
sel  in  2  beverage code, same encoding as dispenser BVMin
cancel  in  1  refund request
BVMvalid  in  1  dispenser busy flag
BVMd  out  1  dispense request to dispenser
BVMin  out  2  selection to dispenser, stable whenever BVMd=1
credit  out  7  current credit
ready  out  1  1 only in COLLECT
coin_reject  out  1  one-cycle pulse, coin returned unaccepted
sel_reject  out  1  one-cycle pulse, selection refused
change_valid  out  1  one-cycle change strobe
change_amt  out  7  change value, valid with change_valid

Behaviour:
- One clock (BVMclk). Reset is synchronous and active-high (BVMrst). All outputs are registered.
- Reset values: state=COLLECT, credit=0, BVMd=0, BVMin=00, ready=1, and all pulses and change_amt=0. Reset mid-operation abandons the transaction with no refund pulse and clears credit.
- States: COLLECT, ISSUE, WAIT_ACK, WAIT_DONE, CHANGE.
- COLLECT, per-cycle priority is cancel > sel_valid > coin_valid:
  - cancel: change_amt=credit, credit=0, go to CHANGE. A coin in the same cycle gets coin_reject.
  - sel_valid with credit >= price(sel): latch BVMin=sel, latch change_amt=credit-price, go to ISSUE. A coin in the same cycle gets coin_reject.
  - sel_valid with credit < price: sel_reject pulse, stay in COLLECT. A coin in the same cycle is still processed.
  - coin_valid: if credit+value <= MAX_CREDIT, add the value. Otherwise coin_reject and credit is unchanged. Arithmetic is 8-bit internally, so there is no wrap.
- ISSUE: BVMd=1 for one cycle, then go to WAIT_ACK. From acceptance, BVMd rises 1 cycle later.
- WAIT_ACK: BVMd stays 1.
  - When BVMvalid is sampled 1: BVMd goes 0 on that edge and state goes to WAIT_DONE. This prevents a re-trigger when the dispenser frees up.
  - If ACK_TIMEOUT cycles pass without BVMvalid: BVMd=0, change_amt=credit (full refund), go to CHANGE.
- WAIT_DONE: wait while BVMvalid=1. When BVMvalid is sampled 0, go to CHANGE.
- CHANGE:
  - change_valid=1 for exactly one cycle, even if change_amt=0.
  - credit=0. Go to COLLECT.
- Outside COLLECT: coin_valid produces coin_reject, and sel_valid produces sel_reject. cancel is ignored.
- credit is deducted only on entry to CHANGE, so the displayed credit stays until the transaction completes.

Decomposition:
- Package bvm_pkg holds:
  - state enum
  - beverage code constants (WATER=00, MILK=01, TEA=10, COFFEE=11), shared with the dispenser
  - coin value lookup function
  - credit width constant (7)
- One natural sub-module, bvm_price_lut: combinational sel -> price using the parameters. Everything else stays in the FSM.

Test Plan:
- Insert coins 10,10 then sel=11 (coffee, 20) -> BVMd=1 with BVMin=11 one cycle after sel, dispenser busy 10 cycles, then change_valid with change_amt=0 and credit=0.
- Insert 10,5,2 then sel=00 (water, 5) -> change_amt=12 after BVMvalid falls. The dispenser sees exactly one request.
- credit=3, sel=10 (tea, 15) -> sel_reject pulse, credit stays 3, BVMd stays 0.
- credit=95, insert 10 -> coin_reject and credit stays 95. Then insert 5 -> credit=100.
- credit=12, assert cancel and coin_valid in the same cycle -> coin_reject, change_amt=12, return to COLLECT.
- Accepted selection with BVMvalid held 0 -> BVMd drops after 4 cycles and change_amt equals the full credit. Also: BVMrst during WAIT_DONE returns all outputs to reset values on the next edge.
